// File: rtl/slice_adder_seq_pkg.sv
// Shared types and sizing helpers for the multi-cycle slice adder/subtractor.
package slice_adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_slices(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice counter width; a single-slice build still needs a one-bit counter.
    function automatic int cnt_width(input int width, input int slice);
        int n;
        n = width / slice;
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slice_adder_seq_if.sv
// Request/result bundle of the slice adder: operands in, handshake and result out.
interface slice_adder_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/slice_adder_seq_ripple_slice.sv
// One-bit full-adder cell and the SLICE-bit ripple chain built from it.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic o,
    output logic c_out
);
    assign o     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module ripple_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] o,
    output logic             c_out
);
    logic [SLICE:0] c_s;

    assign c_s[0] = c_in;
    assign c_out  = c_s[SLICE];

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        fa_cell u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (c_s[i]),
            .o    (o[i]),
            .c_out(c_s[i+1])
        );
    end
endmodule

// File: rtl/slice_adder_seq.sv
// Multi-cycle WIDTH-bit add/subtract: one SLICE-bit ripple slice per clock, LSB first,
// with the inter-slice carry held in a register.
module slice_adder_seq
    import slice_adder_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    slice_adder_seq_if.slave bus
);
    localparam int N   = num_slices(WIDTH, SLICE);
    localparam int CW  = cnt_width(WIDTH, SLICE);
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sub_r;
    logic             carry_r;
    logic [CW-1:0]    k_r;
    logic [WIDTH:0]   result_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic [SLICE-1:0] a_slice_s;
    logic [SLICE-1:0] b_slice_s;
    logic [SLICE-1:0] sum_s;
    logic             cout_s;
    logic             last_s;

    assign a_slice_s = a_r[int'(k_r) * SLICE +: SLICE];
    assign b_slice_s = b_r[int'(k_r) * SLICE +: SLICE];
    assign last_s    = (k_r == K_LAST);

    ripple_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a    (a_slice_s),
        .b    (b_slice_s),
        .c_in (carry_r),
        .o    (sum_s),
        .c_out(cout_s)
    );

    // Next-state logic of the IDLE -> RUN -> DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture, slice iteration and result/flag accumulation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            carry_r  <= 1'b0;
            k_r      <= '0;
            result_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert B now, inject the +1 as carry-in.
                        a_r      <= bus.a;
                        b_r      <= bus.sub ? ~bus.b : bus.b;
                        sub_r    <= bus.sub;
                        carry_r  <= bus.sub;
                        k_r      <= '0;
                        result_r <= '0;
                        ovf_r    <= 1'b0;
                    end
                end
                RUN: begin
                    result_r[int'(k_r) * SLICE +: SLICE] <= sum_s;
                    carry_r <= cout_s;
                    k_r     <= k_r + CW'(1);
                    if (last_s) begin
                        result_r[WIDTH] <= cout_s ^ sub_r;
                        ovf_r <= (a_r[MSB] == b_r[MSB]) && (sum_s[SLICE-1] != a_r[MSB]);
                    end
                end
                DONE: begin
                    k_r <= '0;
                end
                default: begin
                    k_r <= '0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_slice_adder_seq.sv
// Scoreboard bench for slice_adder_seq: three builds (SLICE=8, 16, 1) against a behavioural model.
module tb_slice_adder_seq;

    typedef struct {
        logic [16:0] res;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        st8 = 1'b0, st16 = 1'b0, st1 = 1'b0;
    logic        sub_d = 1'b0;
    logic [15:0] a_d = 16'h0, b_d = 16'h0;

    int n_total = 0, n_bad = 0, cyc = 0;
    int cnt8 = 0, cnt16 = 0, cnt1 = 0, exp8 = 0, exp16 = 0, exp1 = 0;
    exp_t q8[$], q16[$], q1[$];
    exp_t e8m, e16m, e1m;

    slice_adder_seq_if #(.WIDTH(16)) if8 ();
    slice_adder_seq_if #(.WIDTH(16)) if16 ();
    slice_adder_seq_if #(.WIDTH(16)) if1 ();

    assign if8.start  = st8;  assign if8.sub  = sub_d; assign if8.a  = a_d; assign if8.b  = b_d;
    assign if16.start = st16; assign if16.sub = sub_d; assign if16.a = a_d; assign if16.b = b_d;
    assign if1.start  = st1;  assign if1.sub  = sub_d; assign if1.a  = a_d; assign if1.b  = b_d;

    slice_adder_seq #(.WIDTH(16), .SLICE(8))  u8  (.clock(clock), .reset(reset), .bus(if8.slave));
    slice_adder_seq #(.WIDTH(16), .SLICE(16)) u16 (.clock(clock), .reset(reset), .bus(if16.slave));
    slice_adder_seq #(.WIDTH(16), .SLICE(1))  u1  (.clock(clock), .reset(reset), .bus(if1.slave));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent reference: {overflow, borrow/carry, 16-bit result}.
    function automatic logic [17:0] model(input logic s, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] r;
        logic        o;
        if (!s) begin
            r = {1'b0, x} + {1'b0, y};
            o = (x[15] == y[15]) && (r[15] != x[15]);
        end else begin
            r[15:0] = x - y;
            r[16]   = (x < y);
            o = (x[15] != y[15]) && (r[15] != x[15]);
        end
        return {o, r};
    endfunction

    // Called at a negedge with the selected DUTs idle; returns one cycle later.
    task automatic issue(input logic s, input logic [15:0] x, input logic [15:0] y,
                         input bit e8, input bit e16, input bit e1);
        logic [17:0] m;
        exp_t e;
        m = model(s, x, y);
        e.res = m[16:0];
        e.ovf = m[17];
        sub_d = s; a_d = x; b_d = y;
        st8 = e8; st16 = e16; st1 = e1;
        if (e8)  begin e.due = cyc + 3;  q8.push_back(e);  exp8++;  end
        if (e16) begin e.due = cyc + 2;  q16.push_back(e); exp16++; end
        if (e1)  begin e.due = cyc + 17; q1.push_back(e);  exp1++;  end
        @(negedge clock);
        st8 = 1'b0; st16 = 1'b0; st1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((if8.busy || if16.busy || if1.busy) && n < 60);
        check_val("idle", {if8.busy, if16.busy, if1.busy}, 32'd0);
    endtask

    always @(negedge clock) begin
        if (!reset && if8.done) begin
            cnt8++;
            if (q8.size() > 0) begin
                e8m = q8.pop_front();
                check_val("res8", if8.result, e8m.res);
                check_val("ovf8", if8.overflow, e8m.ovf);
                check_val("lat8", cyc, e8m.due);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && if16.done) begin
            cnt16++;
            if (q16.size() > 0) begin
                e16m = q16.pop_front();
                check_val("res16", if16.result, e16m.res);
                check_val("ovf16", if16.overflow, e16m.ovf);
                check_val("lat16", cyc, e16m.due);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && if1.done) begin
            cnt1++;
            if (q1.size() > 0) begin
                e1m = q1.pop_front();
                check_val("res1", if1.result, e1m.res);
                check_val("ovf1", if1.overflow, e1m.ovf);
                check_val("lat1", cyc, e1m.due);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check_val("rst_flags", {if8.busy, if8.done, if8.overflow, if16.busy, if1.busy}, 32'd0);
        check_val("rst_result", if8.result, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Basic add with busy window: high for exactly three cycles.
        issue(1'b0, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_val("busy_hi", if8.busy, 32'd1);
            @(negedge clock);
        end
        check_val("busy_lo", if8.busy, 32'd0);
        wait_idle();

        issue(1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b1); wait_idle();
        issue(1'b0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0); wait_idle();
        issue(1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0); wait_idle();
        issue(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0); wait_idle();

        // Start pulse during RUN must be dropped; the first result must hold afterwards.
        issue(1'b0, 16'h1234, 16'h1111, 1'b1, 1'b0, 1'b0);
        st8 = 1'b1; sub_d = 1'b1; a_d = 16'hAAAA; b_d = 16'h5555;
        @(negedge clock);
        st8 = 1'b0;
        wait_idle();
        repeat (3) @(negedge clock);
        check_val("hold_res", if8.result, 32'h02345);
        check_val("ign_cnt", cnt8, exp8);

        // Abort mid-RUN: everything reads zero, then a fresh operation completes.
        issue(1'b0, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        q8.delete();
        exp8--;
        @(negedge clock);
        check_val("abort_flags", {if8.busy, if8.done, if8.overflow}, 32'd0);
        check_val("abort_res", if8.result, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        issue(1'b1, 16'h1000, 16'h0234, 1'b1, 1'b0, 1'b0); wait_idle();

        for (int i = 0; i < 1000; i++) begin
            issue(1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()), 1'b1, 1'b1, 1'b1);
            wait_idle();
        end

        repeat (5) @(negedge clock);
        check_val("cnt8", cnt8, exp8);
        check_val("cnt16", cnt16, exp16);
        check_val("cnt1", cnt1, exp1);
        check_val("pending", q8.size() + q16.size() + q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
